regfile_scoreboard: RTL

- Architectural integer register file: the receiving end of the writeback interface (address, data, write-enable) driven by the writeback stage.
- Serves two combinational read ports to decode, with write-to-read bypass.
- Keeps a per-register outstanding-write scoreboard so decode stalls instead of reading stale operands while a producer is still in the 3-stage execute/writeback pipeline.

---
 rtl/regfile_scoreboard_pkg.sv | 11 +
 rtl/sb_counter.sv | 34 +++
 rtl/regfile_scoreboard.sv | 102 ++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file constants: architectural sizes and the scoreboard depth
// (at most three writes to one register can be in the execute/writeback pipe).
package regfile_scoreboard_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;
  localparam int NUM_REGS       = 32;
  localparam int CNT_WIDTH      = 2;
  localparam int SB_CNT_MAX     = 3;

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: counts outstanding writes to a single register.
// Saturates at MAX_COUNT and never drops below zero.
module sb_counter
  import regfile_scoreboard_pkg::*;
#(
  parameter int CNT_WIDTH = regfile_scoreboard_pkg::CNT_WIDTH,
  parameter int MAX_COUNT = SB_CNT_MAX
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count
);

  logic dec_ok;
  logic at_max;

  // A writeback for a register with nothing outstanding (e.g. after a
  // mid-flight reset) must not wrap the counter.
  assign dec_ok = dec && (count != '0);
  assign at_max = (count == CNT_WIDTH'(MAX_COUNT));

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && !dec_ok && !at_max) begin
      count <= count + CNT_WIDTH'(1);
    end else if (dec_ok && !inc) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with two bypassed read ports and a per-register
// outstanding-write scoreboard that stalls decode on unready operands.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = regfile_scoreboard_pkg::REG_ADDR_WIDTH,
  parameter int DATA_WIDTH     = regfile_scoreboard_pkg::DATA_WIDTH,
  parameter int NUM_REGS       = regfile_scoreboard_pkg::NUM_REGS,
  parameter int CNT_WIDTH      = regfile_scoreboard_pkg::CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic                      rs1_used,
  input  logic                      rs2_used,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic                      issue_wr,
  output logic [DATA_WIDTH-1:0]     rs1_data,
  output logic [DATA_WIDTH-1:0]     rs2_data,
  output logic                      stall
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt  [NUM_REGS];

  logic wb_live;
  logic wb_hit1;
  logic wb_hit2;
  logic wb_hit_rd;
  logic rdy1;
  logic rdy2;
  logic full;

  assign wb_live   = wb_en && (wb_addr != '0);
  assign wb_hit1   = wb_en && (wb_addr == rs1_addr);
  assign wb_hit2   = wb_en && (wb_addr == rs2_addr);
  assign wb_hit_rd = wb_en && (wb_addr == issue_rd);

  function automatic logic operand_ready(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic                      used,
    input logic [CNT_WIDTH-1:0]      count,
    input logic                      wb_hit
  );
    // The last outstanding producer writing back this cycle is as good as
    // done: its data reaches the operand through the bypass.
    return !used || (addr == '0) || (count == '0) ||
           ((count == CNT_WIDTH'(1)) && wb_hit);
  endfunction

  // ---- architectural state: data array ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // ---- architectural state: scoreboard, x0 never has producers ----
  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    logic inc;
    logic dec;

    assign inc = issue_valid && issue_wr && (issue_rd == REG_ADDR_WIDTH'(r));
    assign dec = wb_en && (wb_addr == REG_ADDR_WIDTH'(r));

    sb_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .MAX_COUNT (SB_CNT_MAX)
    ) u_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (inc),
      .dec   (dec),
      .count (cnt[r])
    );
  end

  // ---- combinational read ports with same-cycle writeback bypass ----
  assign rs1_data = (rs1_addr == '0) ? '0 :
                    wb_hit1          ? wb_data : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 :
                    wb_hit2          ? wb_data : regs[rs2_addr];

  // ---- hazard detection on pre-update counts ----
  assign rdy1  = operand_ready(rs1_addr, rs1_used, cnt[rs1_addr], wb_hit1);
  assign rdy2  = operand_ready(rs2_addr, rs2_used, cnt[rs2_addr], wb_hit2);
  assign full  = issue_wr && (issue_rd != '0) &&
                 (cnt[issue_rd] == CNT_WIDTH'(SB_CNT_MAX)) && !wb_hit_rd;
  assign stall = !rdy1 || !rdy2 || full;

endmodule
